keypad_scanner: RTL and testbench

- Scans a 4x4 matrix keypad and debounces key presses.
- Encodes each accepted press into a 4-bit hex code.
- Keeps a two-digit history (newest and previous key) that feeds the dual seven-segment display path; each history digit drives one hex-to-segment decoder.
- Drives keypad columns active-low and reads rows active-low (rows have pull-ups).

---
 rtl/keypad_scanner.sv | 150 +++++++++++++++
 tb/tb_keypad_scanner.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column scan, press/release debounce, hex encode,
// and a two-digit history (newest/previous key) for the seven-segment path.
module keypad_scanner #(
    parameter int SCAN_DIV        = 50000,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_held,
    output logic [3:0] new_digit,
    output logic [3:0] old_digit
);

    localparam int MAXP = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
    localparam int CW   = $clog2(MAXP) + 1;
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

    state_t        state_reg, state_next;
    logic [3:0]    sync_reg, rs_reg;
    logic [CW-1:0] cnt_reg, cnt_next, cnt_inc;
    logic [1:0]    col_reg, col_next;
    logic [1:0]    row_reg, row_next;
    logic [3:0]    key_reg, key_next;
    logic          valid_reg, valid_next;
    logic [3:0]    new_reg, new_next;
    logic [3:0]    old_reg, old_next;
    logic [1:0]    low_row;
    logic          row_low;

    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
            4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
            4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
            4'hC: code = 4'hE;  4'hD: code = 4'h0;  4'hE: code = 4'hF;  default: code = 4'hD;
        endcase
        return code;
    endfunction

    // Scan downward so the lowest-index active row wins.
    always_comb begin
        low_row = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rs_reg[i]) low_row = 2'(i);
        end
    end

    assign row_low = !rs_reg[row_reg];
    assign cnt_inc = (cnt_reg == '1) ? cnt_reg : cnt_reg + CW'(1);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        col_next   = col_reg;
        row_next   = row_reg;
        key_next   = key_reg;
        valid_next = 1'b0;
        new_next   = new_reg;
        old_next   = old_reg;
        case (state_reg)
            SCAN: begin
                if (rs_reg != 4'b1111) begin
                    row_next   = low_row;
                    cnt_next   = '0;
                    state_next = DEBOUNCE;
                end else if (cnt_reg >= SCAN_LAST) begin
                    cnt_next = '0;
                    col_next = col_reg + 2'd1;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            DEBOUNCE: begin
                if (!row_low) begin
                    cnt_next   = '0;
                    col_next   = col_reg + 2'd1;
                    state_next = SCAN;
                end else if (cnt_reg >= DEB_LAST) begin
                    key_next   = key_code(row_reg, col_reg);
                    valid_next = 1'b1;
                    old_next   = new_reg;
                    new_next   = key_code(row_reg, col_reg);
                    state_next = HELD;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            HELD: begin
                if (!row_low) begin
                    cnt_next   = '0;
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                if (row_low) begin
                    state_next = HELD;
                end else if (cnt_reg >= DEB_LAST) begin
                    cnt_next   = '0;
                    col_next   = col_reg + 2'd1;
                    state_next = SCAN;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            default: state_next = SCAN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= SCAN;
            sync_reg  <= 4'b1111;
            rs_reg    <= 4'b1111;
            cnt_reg   <= '0;
            col_reg   <= 2'd0;
            row_reg   <= 2'd0;
            key_reg   <= 4'd0;
            valid_reg <= 1'b0;
            new_reg   <= 4'd0;
            old_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            sync_reg  <= rows;
            rs_reg    <= sync_reg;
            cnt_reg   <= cnt_next;
            col_reg   <= col_next;
            row_reg   <= row_next;
            key_reg   <= key_next;
            valid_reg <= valid_next;
            new_reg   <= new_next;
            old_reg   <= old_next;
        end
    end

    assign cols      = ~(4'b0001 << col_reg);
    assign key       = key_reg;
    assign key_valid = valid_reg;
    assign key_held  = (state_reg == HELD) || (state_reg == RELEASE);
    assign new_digit = new_reg;
    assign old_digit = old_reg;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a combinational 4x4 keypad model.
module tb_keypad_scanner;

    logic       clk;
    logic       reset;
    logic [3:0] rows;
    logic [3:0] cols;
    logic [3:0] key;
    logic       key_valid;
    logic       key_held;
    logic [3:0] new_digit;
    logic [3:0] old_digit;
    logic [15:0] down;

    int total = 0;
    int bad   = 0;
    int pulses = 0;

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(8)) dut (
        .clk(clk), .reset(reset), .rows(rows), .cols(cols), .key(key),
        .key_valid(key_valid), .key_held(key_held),
        .new_digit(new_digit), .old_digit(old_digit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Key (r,c) pulls row r low only while column c is driven low.
    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (down[r*4+c] && !cols[c]) rows[r] = 1'b0;
    end

    always @(posedge clk) if (key_valid) pulses <= pulses + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    int p0;
    int drops;
    logic [3:0] c0;
    bit seen;

    initial begin
        reset = 1'b0;
        down  = '0;
        tick(2);
        check("rst_cols", cols, 4'b1110);
        check("rst_key", key, 0);
        check("rst_valid", key_valid, 0);
        check("rst_held", key_held, 0);
        check("rst_new", new_digit, 0);
        check("rst_old", old_digit, 0);
        reset = 1'b1;
        tick(4);
        check("scan_c1", cols, 4'b1101);
        tick(12);
        check("scan_wrap", cols, 4'b1110);
        $display("reset/scan checked");

        // Single press of 5
        p0 = pulses;
        down[5] = 1'b1;
        tick(40);
        check("p5_pulses", pulses - p0, 1);
        check("p5_key", key, 4'h5);
        check("p5_new", new_digit, 4'h5);
        check("p5_old", old_digit, 4'h0);
        check("p5_held", key_held, 1);
        down = '0;
        tick(8);
        check("p5_held_rel", key_held, 1);
        tick(12);
        check("p5_held_off", key_held, 0);
        $display("press 5 checked");

        // Short bounce on 5 while its column is driven
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (cols == 4'b1101) seen = 1;
            else tick(1);
        end
        check("bnc_col_wait", seen, 1);
        p0 = pulses;
        down[5] = 1'b1;
        tick(3);
        down = '0;
        tick(30);
        check("bnc_pulses", pulses - p0, 0);
        check("bnc_new", new_digit, 4'h5);
        check("bnc_old", old_digit, 4'h0);
        check("bnc_held", key_held, 0);
        c0 = cols;
        tick(4);
        check("bnc_rotate", cols, {c0[2:0], c0[3]});
        $display("bounce checked");

        // Second key while first is held
        p0 = pulses;
        down[5] = 1'b1;
        tick(40);
        down[3] = 1'b1;
        tick(40);
        check("two_pulses", pulses - p0, 1);
        check("two_key", key, 4'h5);
        down = '0;
        tick(20);
        down[3] = 1'b1;
        tick(40);
        check("a_pulses", pulses - p0, 2);
        check("a_key", key, 4'hA);
        check("a_new", new_digit, 4'hA);
        check("a_old", old_digit, 4'h5);
        down = '0;
        tick(20);
        $display("second key checked");

        // Release bounce on 0
        p0 = pulses;
        down[13] = 1'b1;
        tick(40);
        check("z_key", key, 4'h0);
        check("z_new", new_digit, 4'h0);
        check("z_old", old_digit, 4'hA);
        drops = 0;
        down = '0;
        for (int i = 0; i < 6; i++) begin tick(1); if (!key_held) drops++; end
        down[13] = 1'b1;
        for (int i = 0; i < 10; i++) begin tick(1); if (!key_held) drops++; end
        down = '0;
        for (int i = 0; i < 8; i++) begin tick(1); if (!key_held) drops++; end
        check("z_held_drops", drops, 0);
        tick(12);
        check("z_pulses", pulses - p0, 1);
        check("z_held_off", key_held, 0);
        $display("release bounce checked");

        // Reset while D is held
        p0 = pulses;
        down[15] = 1'b1;
        tick(40);
        check("d_pulses", pulses - p0, 1);
        check("d_key", key, 4'hD);
        reset = 1'b0;
        tick(1);
        check("mr_key", key, 0);
        check("mr_new", new_digit, 0);
        check("mr_old", old_digit, 0);
        check("mr_held", key_held, 0);
        check("mr_cols", cols, 4'b1110);
        reset = 1'b1;
        down = '0;
        p0 = pulses;
        tick(40);
        check("mr_no_pulse", pulses - p0, 0);
        down[15] = 1'b1;
        tick(40);
        check("mr_repress", pulses - p0, 1);
        check("mr_rp_key", key, 4'hD);
        check("mr_rp_new", new_digit, 4'hD);
        check("mr_rp_old", old_digit, 4'h0);
        down = '0;
        tick(20);
        $display("reset mid-held checked");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
